// File: rtl/rv32i_io_arbiter_if.sv
// Bus bundle shared by the two IO masters, the arbiter and the KEY/LED IO block.
//   Master 0 / master 1 request side : reqN, weN, addrN, wdataN  (to arbiter)
//   Master 0 / master 1 response side: gntN, doneN, errN, rdataN (from arbiter)
//   IO block side                    : io_valid, io_we, io_addr, io_wdata (from arbiter),
//                                      io_rdata (from IO block, registered there)
// Modport slave is the arbiter's view; modport master is the view of the
// surrounding system (both requesters plus the IO block).
interface rv32i_io_arbiter_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [31:0]           wdata0;
  logic                  gnt0;
  logic                  done0;
  logic                  err0;
  logic [31:0]           rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [31:0]           wdata1;
  logic                  gnt1;
  logic                  done1;
  logic                  err1;
  logic [31:0]           rdata1;

  logic                  io_valid;
  logic                  io_we;
  logic [ADDR_WIDTH-1:0] io_addr;
  logic [31:0]           io_wdata;
  logic [31:0]           io_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  io_rdata,
    output gnt0, done0, err0, rdata0,
    output gnt1, done1, err1, rdata1,
    output io_valid, io_we, io_addr, io_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output io_rdata,
    input  gnt0, done0, err0, rdata0,
    input  gnt1, done1, err1, rdata1,
    input  io_valid, io_we, io_addr, io_wdata
  );
endinterface

// File: rtl/rv32i_io_arbiter.sv
// Two-master arbiter/sequencer for the single memory-mapped IO port.
// Master 0 (CPU load/store) and master 1 (debug/host) share the KEY/LED block.
// One request is accepted at a time with round-robin fairness; a legal access
// issues a one-cycle io_valid strobe, waits out the IO block's registered read
// latency and returns a registered response. Addresses above IO_LIMIT are
// answered with an error and never strobe the IO block.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : rv32i_io_arbiter_if.slave (request/response of both masters + IO port)
module rv32i_io_arbiter #(
  parameter int                    ADDR_WIDTH = 15,
  parameter logic [ADDR_WIDTH-1:0] IO_LIMIT   = ADDR_WIDTH'(3)
) (
  input  logic                 clk,
  input  logic                 reset,
  rv32i_io_arbiter_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

  state_t                state, state_nxt;
  logic                  err_second, err_second_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  winner, winner_nxt;
  logic                  lat_we, lat_we_nxt;

  logic                  gnt0, gnt0_nxt, gnt1, gnt1_nxt;
  logic                  done0, done0_nxt, done1, done1_nxt;
  logic                  err0, err0_nxt, err1, err1_nxt;
  logic [31:0]           rdata0, rdata0_nxt, rdata1, rdata1_nxt;
  logic                  io_valid, io_valid_nxt, io_we, io_we_nxt;
  logic [ADDR_WIDTH-1:0] io_addr, io_addr_nxt;
  logic [31:0]           io_wdata, io_wdata_nxt;

  logic                  win, pick, pick_we, pick_legal;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [31:0]           pick_wdata;

  // Request selection; only consumed while IDLE. On contention the master
  // that did not win last time is chosen.
  always_comb begin
    win  = 1'b0;
    pick = 1'b0;
    if (bus.req0 && bus.req1) begin
      win  = 1'b1;
      pick = ~last_grant;
    end else if (bus.req0) begin
      win  = 1'b1;
      pick = 1'b0;
    end else if (bus.req1) begin
      win  = 1'b1;
      pick = 1'b1;
    end
    pick_we    = pick ? bus.we1    : bus.we0;
    pick_addr  = pick ? bus.addr1  : bus.addr0;
    pick_wdata = pick ? bus.wdata1 : bus.wdata0;
    pick_legal = (pick_addr <= IO_LIMIT);
  end

  // Next-state and next-output logic; every output is registered, so the
  // values computed here appear one cycle later.
  always_comb begin
    state_nxt      = state;
    err_second_nxt = err_second;
    last_grant_nxt = last_grant;
    winner_nxt     = winner;
    lat_we_nxt     = lat_we;
    gnt0_nxt       = 1'b0;
    gnt1_nxt       = 1'b0;
    done0_nxt      = 1'b0;
    done1_nxt      = 1'b0;
    err0_nxt       = 1'b0;
    err1_nxt       = 1'b0;
    rdata0_nxt     = rdata0;
    rdata1_nxt     = rdata1;
    io_valid_nxt   = 1'b0;
    io_we_nxt      = 1'b0;
    io_addr_nxt    = io_addr;
    io_wdata_nxt   = io_wdata;

    case (state)
      IDLE: begin
        if (win) begin
          winner_nxt     = pick;
          last_grant_nxt = pick;
          lat_we_nxt     = pick_we;
          gnt0_nxt       = ~pick;
          gnt1_nxt       = pick;
          if (pick_legal) begin
            state_nxt    = ISSUE;
            io_valid_nxt = 1'b1;
            io_we_nxt    = pick_we;
            io_addr_nxt  = pick_addr;
            io_wdata_nxt = pick_wdata;
          end else begin
            // Rejected address: IO port outputs keep their previous values.
            state_nxt      = ERR;
            err_second_nxt = 1'b0;
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // io_rdata is valid now (IO block registers it after io_valid);
        // writes return zero.
        state_nxt = RESP;
        if (winner) begin
          done1_nxt  = 1'b1;
          rdata1_nxt = lat_we ? 32'h0 : bus.io_rdata;
        end else begin
          done0_nxt  = 1'b1;
          rdata0_nxt = lat_we ? 32'h0 : bus.io_rdata;
        end
      end
      RESP: state_nxt = IDLE;
      ERR: begin
        // First ERR cycle shows gnt; second shows done+err.
        if (!err_second) begin
          err_second_nxt = 1'b1;
          if (winner) begin
            done1_nxt  = 1'b1;
            err1_nxt   = 1'b1;
            rdata1_nxt = 32'h0;
          end else begin
            done0_nxt  = 1'b1;
            err0_nxt   = 1'b1;
            rdata0_nxt = 32'h0;
          end
        end else begin
          err_second_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      err_second <= 1'b0;
      last_grant <= 1'b1;
      winner     <= 1'b0;
      lat_we     <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= 32'h0;
      rdata1     <= 32'h0;
      io_valid   <= 1'b0;
      io_we      <= 1'b0;
      io_addr    <= '0;
      io_wdata   <= 32'h0;
    end else begin
      state      <= state_nxt;
      err_second <= err_second_nxt;
      last_grant <= last_grant_nxt;
      winner     <= winner_nxt;
      lat_we     <= lat_we_nxt;
      gnt0       <= gnt0_nxt;
      gnt1       <= gnt1_nxt;
      done0      <= done0_nxt;
      done1      <= done1_nxt;
      err0       <= err0_nxt;
      err1       <= err1_nxt;
      rdata0     <= rdata0_nxt;
      rdata1     <= rdata1_nxt;
      io_valid   <= io_valid_nxt;
      io_we      <= io_we_nxt;
      io_addr    <= io_addr_nxt;
      io_wdata   <= io_wdata_nxt;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.done0    = done0;
  assign bus.done1    = done1;
  assign bus.err0     = err0;
  assign bus.err1     = err1;
  assign bus.rdata0   = rdata0;
  assign bus.rdata1   = rdata1;
  assign bus.io_valid = io_valid;
  assign bus.io_we    = io_we;
  assign bus.io_addr  = io_addr;
  assign bus.io_wdata = io_wdata;

endmodule

// File: tb/tb_rv32i_io_arbiter.sv
// Self-checking bench for rv32i_io_arbiter: directed scenarios plus randomized
// single and contended accesses compared against a transaction-level model.
module tb_rv32i_io_arbiter;
  localparam int             AW    = 15;
  localparam logic [AW-1:0]  LIMIT = 15'h0003;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32i_io_arbiter_if #(.ADDR_WIDTH(AW)) bus();
  rv32i_io_arbiter #(.ADDR_WIDTH(AW), .IO_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // IO block stand-in: four registers, read data registered one cycle after io_valid.
  logic [31:0] io_mem [4];
  always @(posedge clk) begin
    if (reset) begin
      io_mem[0]    <= 32'h1;
      io_mem[1]    <= 32'h0;
      io_mem[2]    <= 32'h0;
      io_mem[3]    <= 32'h0;
      bus.io_rdata <= 32'h0;
    end else if (bus.io_valid) begin
      if (bus.io_we) io_mem[bus.io_addr[1:0]] <= bus.io_wdata;
      else           bus.io_rdata <= io_mem[bus.io_addr[1:0]];
    end
  end

  // Transaction-level reference model state.
  logic [31:0] ref_mem [4];
  logic [31:0] ref_rdata [2];
  bit          ref_last;

  function automatic logic gnt_of(bit m);
    return m ? bus.gnt1 : bus.gnt0;
  endfunction
  function automatic logic done_of(bit m);
    return m ? bus.done1 : bus.done0;
  endfunction
  function automatic logic err_of(bit m);
    return m ? bus.err1 : bus.err0;
  endfunction
  function automatic logic [31:0] rdata_of(bit m);
    return m ? bus.rdata1 : bus.rdata0;
  endfunction

  task automatic set_req(input bit m, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [31:0] d);
    if (m) begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic model_reset();
    ref_mem[0]   = 32'h1;
    ref_mem[1]   = 32'h0;
    ref_mem[2]   = 32'h0;
    ref_mem[3]   = 32'h0;
    ref_rdata[0] = 32'h0;
    ref_rdata[1] = 32'h0;
    ref_last     = 1'b1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    set_req(0, 0, 0, '0, 32'h0);
    set_req(1, 0, 0, '0, 32'h0);
    repeat (n) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One access by a single master, checked cycle by cycle from the request edge.
  task automatic run_access(input bit m, input logic w, input logic [AW-1:0] a,
                            input logic [31:0] d);
    bit          legal;
    logic [31:0] exp_rd;
    legal  = (a <= LIMIT);
    exp_rd = (legal && !w) ? ref_mem[a[1:0]] : 32'h0;
    set_req(m, 1, w, a, d);
    @(negedge clk);
    checks++;
    if ({gnt_of(m), gnt_of(!m)} !== 2'b10) begin
      errors++;
      $display("FAIL gnt m%0d: got %b required 10", m, {gnt_of(m), gnt_of(!m)});
    end
    checks++;
    if (bus.io_valid !== legal) begin
      errors++;
      $display("FAIL io_valid m%0d addr %0h: got %b required %b", m, a, bus.io_valid, legal);
    end
    if (legal) begin
      checks++;
      if ({bus.io_we, bus.io_addr, bus.io_wdata} !== {w, a, d}) begin
        errors++;
        $display("FAIL io_bus m%0d: got we=%b addr=%0h wdata=%0h required we=%b addr=%0h wdata=%0h",
                 m, bus.io_we, bus.io_addr, bus.io_wdata, w, a, d);
      end
    end
    set_req(m, 0, 0, '0, 32'h0);
    if (legal) begin
      if (w) ref_mem[a[1:0]] = d;
      @(negedge clk);
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.io_valid} !== 5'b0) begin
        errors++;
        $display("FAIL wait_quiet m%0d: got %b required 00000", m,
                 {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.io_valid});
      end
    end
    @(negedge clk);
    checks++;
    if ({done_of(m), err_of(m), done_of(!m), err_of(!m), bus.io_valid} !== {1'b1, !legal, 3'b000}) begin
      errors++;
      $display("FAIL done m%0d addr %0h: got %b required %b", m, a,
               {done_of(m), err_of(m), done_of(!m), err_of(!m), bus.io_valid}, {1'b1, !legal, 3'b000});
    end
    checks++;
    if (rdata_of(m) !== exp_rd) begin
      errors++;
      $display("FAIL rdata m%0d addr %0h: got %0h required %0h", m, a, rdata_of(m), exp_rd);
    end
    checks++;
    if (rdata_of(!m) !== ref_rdata[!m]) begin
      errors++;
      $display("FAIL rdata_hold m%0d: got %0h required %0h", !m, rdata_of(!m), ref_rdata[!m]);
    end
    ref_rdata[m] = exp_rd;
    ref_last     = m;
    @(negedge clk);
    checks++;
    if ({bus.done0, bus.done1, bus.err0, bus.err1} !== 4'b0) begin
      errors++;
      $display("FAIL done_pulse m%0d: got %b required 0000", m,
               {bus.done0, bus.done1, bus.err0, bus.err1});
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.io_valid, bus.io_we} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0", {bus.gnt0, bus.gnt1, bus.done0, bus.done1,
               bus.err0, bus.err1, bus.io_valid, bus.io_we});
    end
    checks++;
    if ((bus.io_addr | bus.io_wdata | bus.rdata0 | bus.rdata1) !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0h wdata=%0h rdata0=%0h rdata1=%0h required 0",
               bus.io_addr, bus.io_wdata, bus.rdata0, bus.rdata1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.io_valid} !== 3'b0) begin
      errors++;
      $display("FAIL idle_no_req: got %b required 000", {bus.gnt0, bus.gnt1, bus.io_valid});
    end
  endtask

  task automatic test_read();
    run_access(0, 0, 15'h0000, 32'h0);
  endtask

  task automatic test_write();
    run_access(1, 1, 15'h0001, 32'h2AA);
    run_access(0, 0, 15'h0001, 32'h0);
  endtask

  task automatic test_boundary();
    run_access(1, 1, 15'h0003, 32'hCAFE_0003);
    run_access(0, 0, 15'h0003, 32'h0);
    run_access(0, 0, 15'h0004, 32'h0);
    run_access(1, 1, 15'h7FFF, 32'hDEAD_BEEF);
    run_access(1, 0, 15'h0003, 32'h0);
  endtask

  task automatic test_back_to_back();
    bit grant_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int grants = 0;
    int vcount = 0;
    int dcount = 0;
    set_req(0, 1, 0, 15'h0002, 32'h0);
    set_req(1, 1, 0, 15'h0003, 32'h0);
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (bus.io_valid) vcount++;
      if (bus.gnt0 || bus.gnt1) begin
        checks++;
        if (grants >= 4 || (bus.gnt0 && bus.gnt1) || bus.gnt1 !== grant_order[grants]) begin
          errors++;
          $display("FAIL grant_order #%0d: got gnt0=%b gnt1=%b", grants, bus.gnt0, bus.gnt1);
        end
        if (bus.gnt0) bus.req0 = 1'b0;
        if (bus.gnt1) bus.req1 = 1'b0;
        grants++;
        if (grants == 4) begin
          bus.req0 = 1'b0;
          bus.req1 = 1'b0;
        end
      end
      if (bus.done0) begin
        dcount++;
        checks++;
        if (bus.rdata0 !== ref_mem[2]) begin
          errors++;
          $display("FAIL b2b_rdata0: got %0h required %0h", bus.rdata0, ref_mem[2]);
        end
        if (grants < 4) bus.req0 = 1'b1;
      end
      if (bus.done1) begin
        dcount++;
        checks++;
        if (bus.rdata1 !== ref_mem[3]) begin
          errors++;
          $display("FAIL b2b_rdata1: got %0h required %0h", bus.rdata1, ref_mem[3]);
        end
        if (grants < 4) bus.req1 = 1'b1;
      end
    end
    checks++;
    if (grants != 4 || vcount != 4 || dcount != 4) begin
      errors++;
      $display("FAIL b2b_counts: got grants=%0d io_valid=%0d done=%0d required 4 4 4",
               grants, vcount, dcount);
    end
    ref_rdata[0] = ref_mem[2];
    ref_rdata[1] = ref_mem[3];
    ref_last     = 1'b1;
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    set_req(0, 1, 0, 15'h0002, 32'h0);
    @(negedge clk);
    set_req(0, 0, 0, '0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.io_valid, bus.io_we} !== 8'b0 ||
        (bus.io_addr | bus.io_wdata | bus.rdata0 | bus.rdata1) !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got flags=%b rdata0=%0h rdata1=%0h addr=%0h required 0",
               {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.io_valid, bus.io_we},
               bus.rdata0, bus.rdata1, bus.io_addr);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.io_valid) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid_stray: got %0d active cycles required 0", stray);
    end
    set_req(0, 1, 0, 15'h0000, 32'h0);
    set_req(1, 1, 0, 15'h0001, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_first_grant: got %b required 10", {bus.gnt0, bus.gnt1});
    end
    set_req(0, 0, 0, '0, 32'h0);
    set_req(1, 0, 0, '0, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.done0, bus.rdata0} !== {1'b1, ref_mem[0]}) begin
      errors++;
      $display("FAIL reset_mid_done: got done0=%b rdata0=%0h required 1 %0h", bus.done0, bus.rdata0, ref_mem[0]);
    end
    ref_rdata[0] = ref_mem[0];
    ref_last     = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [AW-1:0] a0, a1;
        bit            w;
        a0 = AW'($urandom_range(0, 3));
        a1 = AW'($urandom_range(0, 3));
        w  = !ref_last;
        set_req(0, 1, 0, a0, 32'h0);
        set_req(1, 1, 0, a1, 32'h0);
        @(negedge clk);
        checks++;
        if ({gnt_of(w), gnt_of(!w)} !== 2'b10) begin
          errors++;
          $display("FAIL rand_contention %0d: got gnt0=%b gnt1=%b required winner m%0d",
                   i, bus.gnt0, bus.gnt1, w);
        end
        set_req(0, 0, 0, '0, 32'h0);
        set_req(1, 0, 0, '0, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if ({done_of(w), done_of(!w), rdata_of(w)} !== {2'b10, ref_mem[w ? a1[1:0] : a0[1:0]]}) begin
          errors++;
          $display("FAIL rand_contention_done %0d: got done=%b rdata=%0h required 10 %0h", i,
                   {done_of(w), done_of(!w)}, rdata_of(w), ref_mem[w ? a1[1:0] : a0[1:0]]);
        end
        ref_rdata[w] = ref_mem[w ? a1[1:0] : a0[1:0]];
        ref_last     = w;
        @(negedge clk);
      end else begin
        run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 5)), $urandom);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_req(0, 0, 0, '0, 32'h0);
    set_req(1, 0, 0, '0, 32'h0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv32i_io_arbiter.md
Name: rv32i_io_arbiter

Overview:
Two-master arbiter and sequencer for the single memory-mapped IO port (KEY/LED block). It shares the IO port between the CPU load/store path (master 0) and the debug/host path (master 1). It accepts one request at a time with round-robin fairness and drives a one-cycle IO access strobe. It waits out the IO block's registered read latency, then returns a registered response to the winning master. Out-of-window addresses are rejected with an error response and never reach the IO block.

Parameters:
ADDR_WIDTH, 15, width of every IO address bus.
IO_LIMIT, 15'h0003, highest legal IO address (inclusive). Addresses above it return an error.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req0  in  1  master 0 request; held high until gnt0
we0  in  1  master 0 write (1) / read (0)
addr0  in  ADDR_WIDTH  master 0 address
wdata0  in  32  master 0 write data
gnt0  out  1  one-cycle pulse: master 0 request accepted
done0  out  1  one-cycle pulse: master 0 response valid
err0  out  1  qualifies done0: address out of window
rdata0  out  32  master 0 read data, valid with done0
req1, we1, addr1, wdata1, gnt1, done1, err1, rdata1  same as master 0, for master 1
io_valid  out  1  one-cycle IO access strobe
io_we  out  1  write enable to IO block; high only when io_valid is high
io_addr  out  ADDR_WIDTH  latched access address
io_wdata  out  32  latched write data
io_rdata  in  32  IO block read data, registered by the IO block (valid the cycle after io_valid)

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; last_grant = 1, so master 0 wins the first contention.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that master wins.
  - Both req: the master != last_grant wins.
  - On any win: latch winner id, we, addr and wdata; update last_grant. If addr <= IO_LIMIT go to ISSUE, else go to ERR.
- ISSUE (1 cycle):
  - gnt_winner = 1, io_valid = 1, io_we = latched we; io_addr/io_wdata = latched values.
  - Next state: WAIT.
- WAIT (1 cycle):
  - io_valid = 0.
  - At the end of the cycle, capture io_rdata when the access was a read; capture 0 when it was a write.
  - Next state: RESP.
- RESP (1 cycle): done_winner = 1, err_winner = 0, rdata_winner = captured value. Next state: IDLE.
- ERR (2 cycles):
  - Cycle 1: gnt_winner = 1, io_valid = 0.
  - Cycle 2: done_winner = 1, err_winner = 1, rdata_winner = 0.
  - Next state: IDLE. Req->done latency matches a legal access minus one cycle.
- Timing: legal access req->gnt = 1 cycle, req->done = 3 cycles, throughput 1 access / 4 cycles. A new req can be sampled in the IDLE cycle that follows RESP.
- Hold-time rules: io_addr and io_wdata hold their last latched values outside ISSUE. rdataN holds its value until that master's next done. done/gnt/err of the non-winning master stay 0.
- Requests are sampled only in IDLE. A req raised or changed in any other state is ignored until the FSM returns to IDLE. A master must drop req after gnt; a req still high in the following IDLE is treated as a new request.
- Simultaneous: both masters requesting continuously alternate grants 0,1,0,1...
- Reset mid-operation: the FSM returns to IDLE immediately. No done is generated for the aborted access, io_valid = 0 the next cycle, and last_grant returns to 1.
- Address compare: unsigned, full ADDR_WIDTH. IO_LIMIT itself is legal.

Test Plan:
- After reset, req0 read addr 0, IO block returns 32'h1 (KEY pressed) -> gnt0 in cycle 1, io_valid=1/io_we=0/io_addr=0 in cycle 1, done0=1/rdata0=32'h1 in cycle 3, err0=0.
- req1 write addr 1 wdata 32'h2AA -> io_valid=1, io_we=1, io_addr=1, io_wdata=32'h2AA in cycle 1; done1 in cycle 3 with rdata1=0; req0/gnt0 untouched.
- req0 and req1 both held, re-asserted after each done, for 4 accesses -> grant order 0,1,0,1; no io_valid overlap; exactly 4 done pulses.
- req0 addr 15'h0004 (> IO_LIMIT) -> io_valid stays 0 throughout; gnt0 in cycle 1; done0=1, err0=1, rdata0=0 in cycle 2.
- reset asserted during WAIT of a master-0 read -> no done0 pulse; all outputs 0 the next cycle; subsequent simultaneous req0/req1 -> master 0 granted first.
